// File: rtl/axi_stream_demux_n_if.sv
// ============================================================================
//  Module   : axi_stream_demux_n_if
//  Purpose  : Bundles the addressed input stream, the per-channel output
//             streams and the drop counter of axi_stream_demux_n.
//  Signals  : tdata_i/taddr_i/tvalid_i/tready_o  - addressed input stream
//             tdata_o[]/tvalid_o/tready_i         - ADDR_NUM output channels
//             drop_cnt_o                          - out-of-range drop count
//             tlast_i/tlast_o                     - only with AXIS_DEMUX_TLAST_EN
//  Modports : slave  - demux side (consumes input stream, drives channels)
//             master - environment side
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_stream_demux_n_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int ADDR_NUM   = 1 << ADDR_WIDTH,
    parameter int CNT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] tdata_i;
    logic [ADDR_WIDTH-1:0] taddr_i;
    logic                  tvalid_i;
    logic                  tready_o;
    logic [DATA_WIDTH-1:0] tdata_o [0:ADDR_NUM-1];
    logic [ADDR_NUM-1:0]   tvalid_o;
    logic [ADDR_NUM-1:0]   tready_i;
    logic [CNT_WIDTH-1:0]  drop_cnt_o;
`ifdef AXIS_DEMUX_TLAST_EN
    logic                  tlast_i;
    logic                  tlast_o;

    modport slave (
        input  tdata_i, taddr_i, tvalid_i, tready_i, tlast_i,
        output tready_o, tdata_o, tvalid_o, drop_cnt_o, tlast_o
    );
    modport master (
        output tdata_i, taddr_i, tvalid_i, tready_i, tlast_i,
        input  tready_o, tdata_o, tvalid_o, drop_cnt_o, tlast_o
    );
`else
    modport slave (
        input  tdata_i, taddr_i, tvalid_i, tready_i,
        output tready_o, tdata_o, tvalid_o, drop_cnt_o
    );
    modport master (
        output tdata_i, taddr_i, tvalid_i, tready_i,
        input  tready_o, tdata_o, tvalid_o, drop_cnt_o
    );
`endif
endinterface

`default_nettype wire

// File: rtl/axi_stream_demux_n.sv
// ============================================================================
//  Module   : axi_stream_demux_n
//  Purpose  : 1:N AXI-Stream router. Each accepted beat is delivered to the
//             output channel named by its address, in strict input order.
//             Registered output stage plus a one-entry skid buffer gives full
//             throughput with tready_o driven straight from a flop.
//             Beats addressed beyond ADDR_NUM are swallowed and counted
//             (saturating). A stalled channel blocks all channels
//             (head-of-line blocking is intentional: ordering is global).
//  Ports    : aclk_i, areset_i (sync, active-high), s_axis (slave modport
//             of axi_stream_demux_n_if).
//  Options  : AXIS_DEMUX_TLAST_EN - adds tlast_i/tlast_o; the route is locked
//             to the first beat's address until tlast, and drops/counting
//             become per packet.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_stream_demux_n #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int ADDR_NUM   = 1 << ADDR_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  wire logic          aclk_i,
    input  wire logic          areset_i,
    axi_stream_demux_n_if.slave s_axis
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [ADDR_WIDTH-1:0] r_skid_addr;
    logic                  r_tready;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic                  w_accept;
    logic                  w_addr_ok;
    logic                  w_drop;
    logic                  w_load;
    logic                  w_cnt_inc;
    logic [ADDR_WIDTH-1:0] w_route_addr;
    logic                  w_out_valid;
    logic [ADDR_NUM-1:0]   w_sel;
    logic                  w_drain;
    logic                  w_out_ld_in;
    logic                  w_out_ld_skid;
    logic                  w_skid_ld;

    assign w_accept  = s_axis.tvalid_i & r_tready;
    assign w_addr_ok = (32'(s_axis.taddr_i) < 32'(ADDR_NUM));

`ifdef AXIS_DEMUX_TLAST_EN
    // r_in_pkt marks that the next beat is a continuation; its route and
    // drop decision come from the lock taken on the packet's first beat.
    logic                  r_in_pkt;
    logic                  r_lock_drop;
    logic [ADDR_WIDTH-1:0] r_lock_addr;
    logic                  r_out_last;
    logic                  r_skid_last;

    assign w_route_addr = r_in_pkt ? r_lock_addr : s_axis.taddr_i;
    assign w_drop       = r_in_pkt ? r_lock_drop : ~w_addr_ok;
    assign w_cnt_inc    = w_accept & ~r_in_pkt & ~w_addr_ok;

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            r_in_pkt    <= 1'b0;
            r_lock_drop <= 1'b0;
            r_lock_addr <= '0;
        end else if (w_accept) begin
            if (s_axis.tlast_i) begin
                r_in_pkt <= 1'b0;
            end else begin
                r_in_pkt <= 1'b1;
                if (!r_in_pkt) begin
                    r_lock_addr <= s_axis.taddr_i;
                    r_lock_drop <= ~w_addr_ok;
                end
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            r_out_last  <= 1'b0;
            r_skid_last <= 1'b0;
        end else begin
            if (w_out_ld_in) begin
                r_out_last <= s_axis.tlast_i;
            end else if (w_out_ld_skid) begin
                r_out_last <= r_skid_last;
            end
            if (w_skid_ld) begin
                r_skid_last <= s_axis.tlast_i;
            end
        end
    end

    assign s_axis.tlast_o = r_out_last;
`else
    assign w_route_addr = s_axis.taddr_i;
    assign w_drop       = ~w_addr_ok;
    assign w_cnt_inc    = w_accept & ~w_addr_ok;
`endif

    // Dropped beats complete the input handshake but never touch storage.
    assign w_load      = w_accept & ~w_drop;
    assign w_out_valid = (r_state != ST_EMPTY);

    // Every channel sees OUT data; tvalid_o qualifies it.
    for (genvar k = 0; k < ADDR_NUM; k++) begin : g_chan
        assign w_sel[k]              = (r_out_addr == ADDR_WIDTH'(k));
        assign s_axis.tvalid_o[k]    = w_out_valid & w_sel[k];
        assign s_axis.tdata_o[k]     = r_out_data;
    end

    assign w_drain = w_out_valid & (|(w_sel & s_axis.tready_i));

    always_comb begin
        w_state_nxt   = r_state;
        w_out_ld_in   = 1'b0;
        w_out_ld_skid = 1'b0;
        w_skid_ld     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_nxt = ST_ONE;
                    w_out_ld_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_load && w_drain) begin
                    w_out_ld_in = 1'b1;
                end else if (w_load) begin
                    w_state_nxt = ST_FULL;
                    w_skid_ld   = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_state_nxt   = ST_ONE;
                    w_out_ld_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // tready_o is computed from the next state so it is already correct in
    // the cycle FULL is entered or left, without a path from tready_i.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            r_state  <= ST_EMPTY;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= (w_state_nxt != ST_FULL);
        end
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
        end else begin
            if (w_out_ld_in) begin
                r_out_data <= s_axis.tdata_i;
                r_out_addr <= w_route_addr;
            end else if (w_out_ld_skid) begin
                r_out_data <= r_skid_data;
                r_out_addr <= r_skid_addr;
            end
            if (w_skid_ld) begin
                r_skid_data <= s_axis.tdata_i;
                r_skid_addr <= w_route_addr;
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            r_drop_cnt <= '0;
        end else if (w_cnt_inc && (r_drop_cnt != {CNT_WIDTH{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign s_axis.tready_o   = r_tready;
    assign s_axis.drop_cnt_o = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_demux_n.sv
// ============================================================================
//  Module   : tb_axi_stream_demux_n
//  Purpose  : Self-checking bench for axi_stream_demux_n. Instance A has 16
//             channels, instance B has 10 channels for out-of-range drops.
//             A per-cycle vector table covers streaming and stall/skid;
//             hand-written sequences cover drops, saturation, reset while
//             full and (with AXIS_DEMUX_TLAST_EN) packet route locking.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_stream_demux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_stream_demux_n_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ADDR_NUM(16), .CNT_WIDTH(8)) ifa ();
    axi_stream_demux_n_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ADDR_NUM(10), .CNT_WIDTH(8)) ifb ();

    axi_stream_demux_n #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ADDR_NUM(16), .CNT_WIDTH(8)) u_dut_a (
        .aclk_i   (clk),
        .areset_i (rst),
        .s_axis   (ifa)
    );

    axi_stream_demux_n #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ADDR_NUM(10), .CNT_WIDTH(8)) u_dut_b (
        .aclk_i   (clk),
        .areset_i (rst),
        .s_axis   (ifb)
    );

    typedef struct {
        logic        vld;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] rdy;
        logic [15:0] exp_vld;
        logic [15:0] exp_data;
        logic        exp_rdy;
    } vec_t;

    vec_t tbl [0:24];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Back-to-back stream: beat k to channel k, seen one cycle later.
        for (int k = 0; k <= 17; k++) begin
            tbl[k].vld      = (k < 16);
            tbl[k].addr     = 4'(k);
            tbl[k].data     = 16'hA000 + 16'(k);
            tbl[k].rdy      = 16'hFFFF;
            tbl[k].exp_vld  = (k >= 1 && k <= 16) ? (16'h1 << (k - 1)) : 16'h0;
            tbl[k].exp_data = 16'hA000 + 16'(k - 1);
            tbl[k].exp_rdy  = 1'b1;
        end
        // Channel 3 stalled: second beat parks in skid, tready_o drops.
        tbl[18] = '{1'b1, 4'd3, 16'h1111, 16'hFFF7, 16'h0000, 16'h0000, 1'b1};
        tbl[19] = '{1'b1, 4'd5, 16'h2222, 16'hFFF7, 16'h0008, 16'h1111, 1'b1};
        tbl[20] = '{1'b0, 4'd0, 16'h0000, 16'hFFF7, 16'h0008, 16'h1111, 1'b0};
        tbl[21] = '{1'b0, 4'd0, 16'h0000, 16'hFFF7, 16'h0008, 16'h1111, 1'b0};
        tbl[22] = '{1'b0, 4'd0, 16'h0000, 16'hFFFF, 16'h0008, 16'h1111, 1'b0};
        tbl[23] = '{1'b0, 4'd0, 16'h0000, 16'hFFF7, 16'h0020, 16'h2222, 1'b1};
        tbl[24] = '{1'b0, 4'd0, 16'h0000, 16'hFFF7, 16'h0000, 16'h0000, 1'b1};

        ifa.tvalid_i = 1'b0; ifa.taddr_i = '0; ifa.tdata_i = '0; ifa.tready_i = '1;
        ifb.tvalid_i = 1'b0; ifb.taddr_i = '0; ifb.tdata_i = '0; ifb.tready_i = '1;
`ifdef AXIS_DEMUX_TLAST_EN
        // Single-beat packets everywhere except the dedicated packet test.
        ifa.tlast_i = 1'b1;
        ifb.tlast_i = 1'b1;
`endif

        // ---------------- reset ----------------
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_tvalid_a", 32'(ifa.tvalid_o), 32'h0);
        chk("rst_tready_a", 32'(ifa.tready_o), 32'h0);
        chk("rst_cnt_a",    32'(ifa.drop_cnt_o), 32'h0);
        chk("rst_tvalid_b", 32'(ifb.tvalid_o), 32'h0);
        chk("rst_data_a",   32'(ifa.tdata_o[7]), 32'h0);
        rst = 1'b0;
        tick();
        chk("rel_tready_a", 32'(ifa.tready_o), 32'h1);
        chk("rel_tready_b", 32'(ifb.tready_o), 32'h1);

        // ---------------- vector table ----------------
        for (int i = 0; i <= 24; i++) begin
            ifa.tvalid_i = tbl[i].vld;
            ifa.taddr_i  = tbl[i].addr;
            ifa.tdata_i  = tbl[i].data;
            ifa.tready_i = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_tvalid", i), 32'(ifa.tvalid_o), 32'(tbl[i].exp_vld));
            chk($sformatf("vec%0d_tready", i), 32'(ifa.tready_o), 32'(tbl[i].exp_rdy));
            for (int k = 0; k < 16; k++)
                if (tbl[i].exp_vld[k])
                    chk($sformatf("vec%0d_data", i), 32'(ifa.tdata_o[k]), 32'(tbl[i].exp_data));
            tick();
        end
        ifa.tvalid_i = 1'b0;
        ifa.tready_i = '1;

        // ---------------- drops on 10-channel instance ----------------
        ifb.tvalid_i = 1'b1; ifb.taddr_i = 4'd12; ifb.tdata_i = 16'hDEAD;
        tick();
        chk("drop_tvalid", 32'(ifb.tvalid_o), 32'h0);
        chk("drop_cnt1",   32'(ifb.drop_cnt_o), 32'h1);
        ifb.taddr_i = 4'd2; ifb.tdata_i = 16'h3333;
        tick();
        chk("after_drop_tvalid", 32'(ifb.tvalid_o), 32'h004);
        chk("after_drop_data",   32'(ifb.tdata_o[2]), 32'h3333);
        ifb.taddr_i = 4'd9; ifb.tdata_i = 16'h9999;
        tick();
        chk("edge9_tvalid", 32'(ifb.tvalid_o), 32'h200);
        chk("edge9_data",   32'(ifb.tdata_o[9]), 32'h9999);
        chk("edge9_cnt",    32'(ifb.drop_cnt_o), 32'h1);
        for (int n = 0; n < 300; n++) begin
            ifb.taddr_i = (n % 2 == 0) ? 4'd10 : 4'd15;
            ifb.tdata_i = 16'(n);
            tick();
            if (n == 252) chk("cnt_254", 32'(ifb.drop_cnt_o), 32'd254);
        end
        chk("cnt_sat",     32'(ifb.drop_cnt_o), 32'd255);
        chk("sat_tvalid",  32'(ifb.tvalid_o), 32'h0);
        ifb.tvalid_i = 1'b0;

        // ---------------- reset while FULL ----------------
        ifa.tready_i = '0;
        ifa.tvalid_i = 1'b1; ifa.taddr_i = 4'd1; ifa.tdata_i = 16'h5555;
        tick();
        ifa.taddr_i = 4'd2; ifa.tdata_i = 16'h6666;
        tick();
        ifa.tvalid_i = 1'b0;
        #1;
        chk("full_tready", 32'(ifa.tready_o), 32'h0);
        chk("full_tvalid", 32'(ifa.tvalid_o), 32'h0002);
        rst = 1'b1;
        tick();
        chk("midrst_tvalid", 32'(ifa.tvalid_o), 32'h0);
        chk("midrst_tready", 32'(ifa.tready_o), 32'h0);
        chk("midrst_cnt_b",  32'(ifb.drop_cnt_o), 32'h0);
        rst = 1'b0;
        ifa.tready_i = '1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("postrst%0d_tvalid", c), 32'(ifa.tvalid_o), 32'h0);
            chk($sformatf("postrst%0d_tready", c), 32'(ifa.tready_o), 32'h1);
        end

`ifdef AXIS_DEMUX_TLAST_EN
        // ---------------- packet route lock ----------------
        for (int i = 0; i < 4; i++) begin
            ifa.tvalid_i = 1'b1;
            ifa.taddr_i  = (i == 0) ? 4'd6 : 4'd1;
            ifa.tdata_i  = 16'hB000 + 16'(i);
            ifa.tlast_i  = (i == 3);
            #1;
            if (i > 0) begin
                chk($sformatf("pkt%0d_tvalid", i - 1), 32'(ifa.tvalid_o), 32'h0040);
                chk($sformatf("pkt%0d_data", i - 1), 32'(ifa.tdata_o[6]), 32'(16'hB000 + 16'(i - 1)));
                chk($sformatf("pkt%0d_tlast", i - 1), 32'(ifa.tlast_o), 32'h0);
            end
            tick();
        end
        ifa.taddr_i = 4'd1; ifa.tdata_i = 16'hC000; ifa.tlast_i = 1'b1;
        #1;
        chk("pkt3_tvalid", 32'(ifa.tvalid_o), 32'h0040);
        chk("pkt3_data",   32'(ifa.tdata_o[6]), 32'hB003);
        chk("pkt3_tlast",  32'(ifa.tlast_o), 32'h1);
        tick();
        ifa.tvalid_i = 1'b0;
        #1;
        chk("pkt2_tvalid", 32'(ifa.tvalid_o), 32'h0002);
        chk("pkt2_data",   32'(ifa.tdata_o[1]), 32'hC000);
        chk("pkt2_tlast",  32'(ifa.tlast_o), 32'h1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_stream_demux_n.md
Name: axi_stream_demux_n

Overview:
- 1:N AXI-Stream router: one input stream carrying a destination address, fanned out to ADDR_NUM output channels.
- Inverse of the N:1 arbitrating mux. Consumes the mux's tdata/taddr output (or any addressed stream) and delivers each beat to the channel named by its address.
- Registered output stage plus one-entry skid buffer: full throughput, ordering preserved, no combinational path from any output tready_i to tready_o.

Parameters:
- DATA_WIDTH, 16, beat width in bits.
- ADDR_WIDTH, 4, width of taddr_i.
- ADDR_NUM, 1 << ADDR_WIDTH, number of output channels; must be 1..2^ADDR_WIDTH.
- CNT_WIDTH, 8, width of the drop counter.

Ports:
- aclk_i  input  1  clock, all logic on rising edge.
- areset_i  input  1  reset, synchronous, active-high.
- tdata_i  input  DATA_WIDTH  input beat data.
- taddr_i  input  ADDR_WIDTH  destination channel of the beat.
- tvalid_i  input  1  input valid.
- tready_o  output  1  input ready, registered.
- tdata_o  output  DATA_WIDTH x ADDR_NUM (unpacked [0:ADDR_NUM-1])  per-channel data.
- tvalid_o  output  ADDR_NUM  per-channel valid; at most one bit set.
- tready_i  input  ADDR_NUM  per-channel ready.
- drop_cnt_o  output  CNT_WIDTH  count of beats discarded for out-of-range address.

Behaviour:
- Reset (areset_i high at a clock edge):
  - All storage invalid, tvalid_o = 0, tready_o = 0, drop_cnt_o = 0, all tdata_o = 0.
  - Reset mid-transfer discards held beats silently.
- First cycle after reset release: tready_o = 1.
- Storage: output register OUT (data, addr, valid) and skid register SKID (data, addr, valid).
- Input handshake: accept = tvalid_i & tready_o.
- Output handshake:
  - drain = OUT.valid & tready_i[OUT.addr].
  - tvalid_o[k] = OUT.valid & (OUT.addr == k).
  - tdata_o[k] = OUT.data for every k; non-selected channels qualify data with tvalid_o.
- State machine (one-hot or encoded):
  - EMPTY: accept -> ONE, beat loaded into OUT.
  - ONE:
    - accept & drain -> ONE (OUT reloaded).
    - accept & !drain -> FULL (beat into SKID).
    - !accept & drain -> EMPTY.
    - else hold.
  - FULL: tready_o = 0.
    - drain -> ONE (SKID moves to OUT).
    - else hold.
- tready_o is registered: 1 in EMPTY/ONE, 0 in FULL.
- Latency: accepted beat appears on tvalid_o the next cycle when OUT is free.
- Throughput: 1 beat/cycle while the addressed channel is ready.
- Ordering: strict input order across all channels. A stalled channel blocks beats for all other channels (head-of-line blocking is intentional and documented).
- Out-of-range address (taddr_i >= ADDR_NUM), checked at acceptance:
  - Beat is accepted and discarded; it never enters OUT or SKID.
  - drop_cnt_o increments by 1, saturating at all-ones.
  - State is unchanged except for any simultaneous drain.
- Stability: held OUT data and address are unchanged while valid and not drained. No tvalid_o bit deasserts without a handshake, except on reset.
- Simultaneous accept and drain in ONE: zero bubble.

Optional Feature:
- Macro: AXIS_DEMUX_TLAST_EN.
- When defined:
  - Adds ports tlast_i (input 1) and tlast_o (output 1, travels with OUT).
  - Route lock: the address sampled on the first beat of a packet is used for every beat until the beat with tlast_i = 1 is accepted; taddr_i on non-first beats is ignored.
  - An out-of-range first beat drops the whole packet through tlast. drop_cnt_o counts dropped packets, not beats.
  - Reset clears the lock; the next beat is a first beat.
- When undefined: no tlast ports, every beat is routed independently by its own taddr_i, and drop_cnt_o counts beats.

Test Plan:
- Reset held 3 cycles, then released -> tvalid_o = 0, drop_cnt_o = 0, tready_o = 0 during reset and 1 on the first cycle after.
- Back-to-back beats 0xA000+k to addr k for k = 0..15, all tready_i = 1 -> each beat appears once on channel k exactly 1 cycle after acceptance, no bubbles, tready_o stays 1.
- Beat 0x1111 to addr 3 with tready_i[3] = 0, then 0x2222 to addr 5 -> tready_o drops to 0 after the second accept, tvalid_o = 0x0008 held stable. Raising tready_i[3] for 1 cycle -> tvalid_o = 0x0020 with 0x2222, tready_o back to 1.
- ADDR_NUM = 10, beat to addr 12, then beat 0x3333 to addr 2 -> no tvalid_o for the first beat, drop_cnt_o = 1, 0x3333 delivered on channel 2. 300 consecutive bad beats -> drop_cnt_o saturates at 255.
- areset_i asserted while in FULL with both entries held -> next cycle tvalid_o = 0 and tready_o = 0, no held beat ever delivered after release.
- With AXIS_DEMUX_TLAST_EN: 4-beat packet, first taddr_i = 6, later beats taddr_i = 1, tlast on beat 4 -> all 4 beats on channel 6 with tlast_o on the 4th. Next packet to addr 1 -> routed to channel 1.
